int_ext_pipe: RTL and testbench

Multi-channel integer-type extension stage with valid/ready handshake on both sides.
- Each channel lane carries a packed integer whose SystemVerilog type is selected per beat: byte, byte unsigned, shortint or shortint unsigned.
- Each lane is sign- or zero-extended to OUT_W bits; a signed cross-channel sum is also produced.
- Results are buffered in a DEPTH-entry output FIFO.
- Sits between packed-sample producers and wide datapath consumers, generalising fixed-type port extension to runtime-selected types, N channels and backpressure.

---
 rtl/int_ext_pkg.sv | 36 +++
 rtl/int_ext_fifo.sv | 60 ++++++
 rtl/int_ext_pipe.sv | 88 ++++++++
 tb/tb_int_ext_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ext_pkg.sv
// Shared types, widths and the lane extension helper for the integer extension stage.
package int_ext_pkg;

  typedef enum logic [1:0] {
    EXT_BYTE_S  = 2'b00,
    EXT_BYTE_U  = 2'b01,
    EXT_SHORT_S = 2'b10,
    EXT_SHORT_U = 2'b11
  } ext_mode_t;

  localparam int BYTE_W  = 8;
  localparam int SHORT_W = 16;
  // One spare bit holds every value of all four source types exactly as a signed number.
  localparam int EXT_W   = SHORT_W + 1;

  // Signed modes are 00 and 10, so bit 0 of the mode selects unsigned.
  function automatic logic mode_is_signed(input ext_mode_t mode);
    return !mode[0];
  endfunction

  // Extended value of one lane. The result is a signed canonical value; the
  // caller size-casts it to OUT_W, which sign-extends for signed types and
  // zero-extends for unsigned ones because bit EXT_W-1 is 0 for those.
  function automatic logic signed [EXT_W-1:0] ext_lane(input ext_mode_t mode,
                                                       input logic [SHORT_W-1:0] lane);
    logic signed [EXT_W-1:0] r;
    case (mode)
      EXT_BYTE_S:  r = {{(EXT_W-BYTE_W){lane[BYTE_W-1]}}, lane[BYTE_W-1:0]};
      EXT_BYTE_U:  r = {{(EXT_W-BYTE_W){1'b0}}, lane[BYTE_W-1:0]};
      EXT_SHORT_S: r = {lane[SHORT_W-1], lane};
      default:     r = {1'b0, lane};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/int_ext_fifo.sv
// Synchronous FIFO with occupancy count; pointers wrap modulo DEPTH (any DEPTH >= 2).
module int_ext_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign w_push  = wr_en && !full && !rst;
  assign w_pop   = rd_en && !empty && !rst;
  // Head is forced to zero when nothing is buffered so idle outputs read as 0.
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointer and occupancy update; push and pop together leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/int_ext_pipe.sv
// Per-lane runtime-typed sign/zero extension with cross-lane sum, buffered in an output FIFO.
module int_ext_pipe
  import int_ext_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16,
  localparam int SUM_W = OUT_W + $clog2(NUM_CH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*IN_W-1:0]  in_data,
  input  logic [NUM_CH*2-1:0]     in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*OUT_W-1:0] out_data,
  output logic [SUM_W-1:0]        out_sum,
  output logic [CNT_W-1:0]        out_beat
);

  localparam int WORD_W = CNT_W + SUM_W + NUM_CH * OUT_W;
  localparam int FCW    = $clog2(DEPTH + 1);

  logic [NUM_CH*OUT_W-1:0] w_data;
  logic [SUM_W-1:0]        w_sum_lane [NUM_CH];
  logic [SUM_W-1:0]        w_psum     [NUM_CH+1];
  logic [CNT_W-1:0]        r_beat_cnt;
  logic                    w_accept;
  logic                    w_full;
  logic                    w_empty;
  logic [FCW-1:0]          w_count;
  logic [WORD_W-1:0]       w_wr_word;
  logic [WORD_W-1:0]       w_rd_word;

  assign w_psum[0] = '0;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    ext_mode_t               w_mode;
    logic signed [EXT_W-1:0] w_canon;
    logic [OUT_W-1:0]        w_ext;

    assign w_mode  = ext_mode_t'(in_mode[2*gi +: 2]);
    assign w_canon = ext_lane(w_mode, in_data[gi*IN_W +: SHORT_W]);
    assign w_ext   = OUT_W'(w_canon);
    assign w_data[gi*OUT_W +: OUT_W] = w_ext;

    // Re-extend the OUT_W lane to the sum width with the signedness of its type.
    always_comb begin
      w_sum_lane[gi] = '0;
      if (mode_is_signed(w_mode)) w_sum_lane[gi] = SUM_W'($signed(w_ext));
      else                        w_sum_lane[gi] = SUM_W'(w_ext);
    end

    assign w_psum[gi+1] = w_psum[gi] + w_sum_lane[gi];
  end

  assign in_ready  = !rst && !w_full;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (w_count != '0);
  assign w_wr_word = {r_beat_cnt, w_psum[NUM_CH], w_data};
  assign {out_beat, out_sum, out_data} = w_rd_word;

  // Beat index counter; the pre-increment value travels with the accepted beat.
  always_ff @(posedge clk) begin
    if (rst)           r_beat_cnt <= '0;
    else if (w_accept) r_beat_cnt <= r_beat_cnt + 1'b1;
  end

  int_ext_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_accept),
    .wr_data (w_wr_word),
    .rd_en   (out_ready && !w_empty),
    .rd_data (w_rd_word),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

endmodule

// File: tb/tb_int_ext_pipe.sv
// Scoreboard bench for int_ext_pipe: expected beats queued on accept, compared on pop.
module tb_int_ext_pipe;

  localparam int NUM_CH = 4;
  localparam int IN_W   = 16;
  localparam int OUT_W  = 32;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 4;
  localparam int SUM_W  = OUT_W + $clog2(NUM_CH) + 1;

  typedef struct {
    logic [NUM_CH*OUT_W-1:0] data;
    logic [SUM_W-1:0]        sum;
    logic [CNT_W-1:0]        beat;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [NUM_CH*IN_W-1:0]  in_data = '0;
  logic [NUM_CH*2-1:0]     in_mode = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [NUM_CH*OUT_W-1:0] out_data;
  logic [SUM_W-1:0]        out_sum;
  logic [CNT_W-1:0]        out_beat;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  logic [CNT_W-1:0] m_beat = '0;
  bit   rand_rdy = 0;

  always #5 clk = ~clk;

  int_ext_pipe #(
    .NUM_CH (NUM_CH), .IN_W (IN_W), .OUT_W (OUT_W), .DEPTH (DEPTH), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data), .in_mode (in_mode),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_data (out_data), .out_sum (out_sum), .out_beat (out_beat)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model built on the native SystemVerilog integer types.
  function automatic exp_t model(input logic [NUM_CH*IN_W-1:0] d, input logic [NUM_CH*2-1:0] m,
                                 input logic [CNT_W-1:0] b);
    exp_t   r;
    longint s = 0;
    r.data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      logic [15:0]     ln;
      int              v;
      byte             sb;
      byte unsigned    ub;
      shortint         ss;
      shortint unsigned us;
      ln = d[i*IN_W +: 16];
      case (m[2*i +: 2])
        2'b00:   begin sb = ln[7:0]; v = sb; end
        2'b01:   begin ub = ln[7:0]; v = ub; end
        2'b10:   begin ss = ln;      v = ss; end
        default: begin us = ln;      v = us; end
      endcase
      r.data[i*OUT_W +: OUT_W] = v;
      s += v;
    end
    r.sum  = s[SUM_W-1:0];
    r.beat = b;
    return r;
  endfunction

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Drive one beat, called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [NUM_CH*IN_W-1:0] d, input logic [NUM_CH*2-1:0] m);
    int waits = 0;
    bit done  = 0;
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(model(d, m, m_beat));
        m_beat++;
        done = 1;
      end else if (++waits > 200) begin
        check_val("send_timeout", in_ready, 1);
        done = 1;
      end else begin
        step();
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      end
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    out_ready = 1'b1;
    while ((sb_q.size() != 0 || in_valid) && n < 200) begin
      step();
      n++;
    end
    check_val("drain_left", sb_q.size(), 0);
    @(negedge clk);
    check_val("drain_idle_valid", out_valid, 0);
    step();
  endtask

  task automatic do_reset;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    m_beat = '0;
    @(negedge clk);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_out_sum", out_sum, 0);
    check_val("rst_out_beat", out_beat, 0);
    check_val("rst_in_ready_after", in_ready, 1);
    step();
  endtask

  // Output monitor: pop and compare on each completing handshake, and check hold stability.
  initial begin
    exp_t e;
    bit   hold = 0;
    logic [NUM_CH*OUT_W-1:0] p_data;
    logic [SUM_W-1:0]        p_sum;
    logic [CNT_W-1:0]        p_beat;
    forever begin
      @(negedge clk);
      if (hold && !rst) begin
        check_val("hold_data", out_data, p_data);
        check_val("hold_sum", out_sum, p_sum);
        check_val("hold_beat", out_beat, p_beat);
      end
      hold   = out_valid && !out_ready && !rst;
      p_data = out_data;
      p_sum  = out_sum;
      p_beat = out_beat;
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_out", out_valid, 0);
        end else begin
          e = sb_q.pop_front();
          check_val("sb_data", out_data, e.data);
          check_val("sb_sum", out_sum, e.sum);
          check_val("sb_beat", out_beat, e.beat);
          $display("OUT beat=%0d data=%h sum=%h", out_beat, out_data, out_sum);
        end
      end
    end
  end

  initial begin
    do_reset();

    // Mixed types on four lanes.
    out_ready = 1'b1;
    send({16'hFFFC, 16'hFFFD, 16'h00FE, 16'h00FF}, 8'b11_10_01_00);
    @(negedge clk);
    check_val("t1_valid", out_valid, 1);
    check_val("t1_data", out_data, 128'h0000FFFC_FFFFFFFD_000000FE_FFFFFFFF);
    check_val("t1_sum", out_sum, 35'd65782);
    check_val("t1_beat", out_beat, 0);
    step();

    // Bits above the selected byte are ignored.
    send(64'h1280, 8'b00);
    @(negedge clk);
    check_val("t2_byte_s", out_data[31:0], 32'hFFFFFF80);
    step();
    send(64'h1280, 8'b01);
    @(negedge clk);
    check_val("t2_byte_u", out_data[31:0], 32'h00000080);
    step();
    drain();

    // Backpressure: third beat held while full.
    do_reset();
    out_ready = 1'b0;
    send(64'h0001_0002_0003_0004, 8'hAA);
    send(64'h8000_7FFF_0080_007F, 8'h00);
    @(negedge clk);
    check_val("t3_full_ready", in_ready, 0);
    step();
    fork
      send(64'hABCD_1234_5678_9ABC, 8'h1B);
    join_none
    repeat (3) @(negedge clk);
    check_val("t3_head_beat", out_beat, 0);
    check_val("t3_queued", sb_q.size(), 2);
    step();
    drain();

    // Continuous streaming at count=1: push and pop in the same cycle.
    out_ready = 1'b1;
    send(64'h1111_2222_3333_4444, 8'h55);
    for (int i = 0; i < 10; i++) begin
      send({$urandom, $urandom}, 8'($urandom));
      check_val("t4_valid", out_valid, 1);
      check_val("t4_ready", in_ready, 1);
    end

    // Random traffic with random out_ready.
    rand_rdy = 1;
    for (int i = 0; i < 100; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) step();
      send({$urandom, $urandom}, 8'($urandom));
    end
    rand_rdy = 0;
    drain();

    // Beat counter wrap with a 4-bit counter.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(64'(i), 8'h00);
    @(negedge clk);
    check_val("t5_wrap_beat", out_beat, 0);
    step();
    drain();

    // Reset with two entries buffered.
    out_ready = 1'b0;
    send(64'h0F0F, 8'h00);
    send(64'hF0F0, 8'h00);
    do_reset();
    out_ready = 1'b1;
    send(64'h7777, 8'h02);
    @(negedge clk);
    check_val("t6_beat_after_rst", out_beat, 0);
    step();
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
